// File: rtl/z_hilo_writeback_pkg.sv
// Shared definitions for the HI/LO result writeback block: FSM state
// encoding and the default datapath width.
package z_hilo_writeback_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HELD    = 3'd1,
    ST_SEND_LO = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/z_hilo_writeback_reg_en.sv
// Enable-loaded register with asynchronous clear; holds one half of the
// captured ALU result pair.
module reg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Load on enable, otherwise hold; clear wipes the held value.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) q_q <= '0;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/z_hilo_writeback.sv
// Captures an ALU result pair (ZHI/ZLO), streams it to a ready/valid bus
// (LO word first, HI word only for 64-bit results) and commits the
// architectural HI/LO registers on the final accepted word.
module z_hilo_writeback
  import z_hilo_writeback_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             z_in,
  input  logic [WIDTH-1:0] zhi_d,
  input  logic [WIDTH-1:0] zlo_d,
  input  logic             wide_op,
  input  logic             wb_start,
  input  logic             bus_ready,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  state_t           state_q, state_d;
  logic             wide_q;
  logic             overrun_q;
  logic [WIDTH-1:0] zhi_r, zlo_r;
  logic             can_capture;
  logic             capture_en;
  logic             dropped;
  logic             final_xfer;

  // A new result can only be taken while no writeback is in flight.
  assign can_capture = (state_q == ST_IDLE) || (state_q == ST_HELD);
  assign capture_en  = z_in && can_capture;
  assign dropped     = z_in && !can_capture;

  reg_en #(.WIDTH(WIDTH)) u_zhi (
    .clock (clock),
    .clear (clear),
    .en_i  (capture_en),
    .d_i   (zhi_d),
    .q_o   (zhi_r)
  );

  reg_en #(.WIDTH(WIDTH)) u_zlo (
    .clock (clock),
    .clear (clear),
    .en_i  (capture_en),
    .d_i   (zlo_d),
    .q_o   (zlo_r)
  );

  // Next-state logic and bus/status outputs; bus_out is driven only from
  // the held registers, never from the ALU inputs.
  always_comb begin
    state_d    = state_q;
    bus_valid  = 1'b0;
    bus_out    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    final_xfer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (z_in) state_d = ST_HELD;
      end
      ST_HELD: begin
        // A fresh capture takes priority over starting the writeback.
        if (z_in) state_d = ST_HELD;
        else if (wb_start) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        busy      = 1'b1;
        bus_valid = 1'b1;
        bus_out   = zlo_r;
        if (bus_ready) begin
          if (wide_q) begin
            state_d = ST_SEND_HI;
          end else begin
            state_d    = ST_DONE;
            final_xfer = 1'b1;
          end
        end
      end
      ST_SEND_HI: begin
        busy      = 1'b1;
        bus_valid = 1'b1;
        bus_out   = zhi_r;
        if (bus_ready) begin
          state_d    = ST_DONE;
          final_xfer = 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, width flag, overrun pulse and HI/LO commit.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      wide_q    <= 1'b0;
      overrun_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      overrun_q <= dropped;
      if (capture_en) wide_q <= wide_op;
      if (final_xfer) begin
        lo_q <= zlo_r;
        if (wide_q) hi_q <= zhi_r;
      end
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_z_hilo_writeback.sv
// Scoreboard bench for z_hilo_writeback: the driver keeps a transaction-level
// model (held pair, architectural HI/LO) and queues expected bus words and
// commits; an independent monitor checks them as the DUT presents them.
module tb_z_hilo_writeback;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear;
  logic         z_in;
  logic [W-1:0] zhi_d;
  logic [W-1:0] zlo_d;
  logic         wide_op;
  logic         wb_start;
  logic         bus_ready;
  logic [W-1:0] bus_out;
  logic         bus_valid;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic         busy;
  logic         done;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_words[$];
  logic [W-1:0] exp_hi[$];
  logic [W-1:0] exp_lo[$];

  logic [W-1:0] m_hi, m_lo, a_hi, a_lo;
  logic         m_wide;
  int           exp_ovr = 0;
  int           act_ovr = 0;

  z_hilo_writeback #(.WIDTH(W)) dut (
    .clock     (clock),
    .clear     (clear),
    .z_in      (z_in),
    .zhi_d     (zhi_d),
    .zlo_d     (zlo_d),
    .wide_op   (wide_op),
    .wb_start  (wb_start),
    .bus_ready (bus_ready),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .hi_q      (hi_q),
    .lo_q      (lo_q),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic capture(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic wide);
    step();
    z_in = 1'b1; zhi_d = hi; zlo_d = lo; wide_op = wide;
    step();
    z_in = 1'b0; zhi_d = $urandom; zlo_d = $urandom; wide_op = 1'($urandom);
    m_hi = hi; m_lo = lo; m_wide = wide;
  endtask

  // Issue wb_start on the held pair. Cycle k=1 is the first cycle after the
  // edge that samples wb_start; bus_ready in cycle k is rdy[k].
  task automatic writeback(input int ready_pct, input int stall_lead, input int inj_k_in);
    bit rdy[64];
    int rem, exp_k, seen, inj_k;
    for (int i = 0; i < 64; i++) begin
      if (i <= stall_lead) rdy[i] = 1'b0;
      else if (i > 20) rdy[i] = 1'b1;
      else rdy[i] = ($urandom_range(99) < ready_pct);
    end
    rem = m_wide ? 2 : 1;
    exp_k = 1;
    while (rem > 0) begin
      if (rdy[exp_k]) rem--;
      exp_k++;
    end
    inj_k = (inj_k_in < exp_k) ? inj_k_in : 0;
    exp_words.push_back(m_lo);
    if (m_wide) exp_words.push_back(m_hi);
    a_lo = m_lo;
    if (m_wide) a_hi = m_hi;
    exp_hi.push_back(a_hi);
    exp_lo.push_back(a_lo);
    if (inj_k > 0) exp_ovr++;
    step();
    wb_start = 1'b1;
    step();
    seen = 0;
    for (int k = 1; k <= 80; k++) begin
      wb_start  = 1'b0;
      z_in      = (k == inj_k);
      if (k == inj_k) begin
        zhi_d = $urandom; zlo_d = $urandom; wide_op = 1'($urandom);
      end
      bus_ready = (k < 64) ? rdy[k] : 1'b1;
      if (inj_k > 0 && k == inj_k + 1) chk("overrun_pulse", 32'(overrun), 32'd1);
      if (done) begin
        seen = k;
        break;
      end
      step();
    end
    z_in = 1'b0;
    if (seen == 0) fail("done_timeout");
    else chk("done_latency", 32'(seen), 32'(exp_k));
    step();
  endtask

  // Monitor: samples after the driver has settled inputs for the coming edge.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (overrun) act_ovr++;
      if (bus_valid) begin
        if (exp_words.size() == 0) fail("unexpected_bus_valid");
        else begin
          chk("bus_word", bus_out, exp_words[0]);
          if (bus_ready) void'(exp_words.pop_front());
        end
      end else begin
        chk("bus_out_zero_when_invalid", bus_out, '0);
      end
      if (done) begin
        if (exp_hi.size() == 0) fail("unexpected_done");
        else begin
          chk("hi_commit", hi_q, exp_hi.pop_front());
          chk("lo_commit", lo_q, exp_lo.pop_front());
        end
      end
    end
  end

  initial begin
    clear = 1'b1; z_in = 1'b0; zhi_d = '0; zlo_d = '0; wide_op = 1'b0;
    wb_start = 1'b0; bus_ready = 1'b1;
    a_hi = '0; a_lo = '0; m_hi = '0; m_lo = '0; m_wide = 1'b0;
    step();
    chk("rst_bus_out", bus_out, '0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_hi_q", hi_q, '0);
    chk("rst_lo_q", lo_q, '0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    step();
    clear = 1'b0;

    // Wide result, ready tied high.
    capture(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    writeback(100, 0, 0);
    // Narrow result: hi_q must keep 0xDEADBEEF.
    capture(32'h0000_0000, 32'h0000_0005, 1'b0);
    writeback(100, 0, 0);
    chk("narrow_hi_unchanged", hi_q, 32'hDEAD_BEEF);
    // Backpressure: three stalled cycles in SEND_LO.
    capture(32'h0, 32'h0000_0077, 1'b0);
    writeback(100, 3, 0);

    // Simultaneous capture and wb_start while HELD.
    capture(32'h0, 32'h0000_0011, 1'b0);
    z_in = 1'b1; wb_start = 1'b1; zlo_d = 32'h0000_00AA; zhi_d = '0; wide_op = 1'b0;
    step();
    z_in = 1'b0; wb_start = 1'b0;
    m_lo = 32'h0000_00AA; m_hi = '0; m_wide = 1'b0;
    step();
    chk("simul_no_send_busy", 32'(busy), 32'd0);
    chk("simul_no_send_valid", 32'(bus_valid), 32'd0);
    writeback(100, 0, 0);

    // Overrun: z_in dropped during SEND_HI.
    capture(32'hCAFE_F00D, 32'h0102_0304, 1'b1);
    writeback(100, 0, 2);

    // wb_start in IDLE is ignored.
    step();
    wb_start = 1'b1;
    step();
    wb_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_wb_valid", 32'(bus_valid), 32'd0);
      chk("idle_wb_busy", 32'(busy), 32'd0);
      step();
    end

    // Clear asserted mid-SEND_HI.
    capture(32'h5555_AAAA, 32'h3333_CCCC, 1'b1);
    exp_words.push_back(32'h3333_CCCC);
    step();
    wb_start = 1'b1; bus_ready = 1'b1;
    step();
    wb_start = 1'b0;
    step();
    chk("pre_clear_busy", 32'(busy), 32'd1);
    bus_ready = 1'b0;
    clear = 1'b1;
    exp_words.delete(); exp_hi.delete(); exp_lo.delete();
    a_hi = '0; a_lo = '0; m_hi = '0; m_lo = '0; m_wide = 1'b0;
    #1;
    chk("clr_bus_out", bus_out, '0);
    chk("clr_bus_valid", 32'(bus_valid), 32'd0);
    chk("clr_hi_q", hi_q, '0);
    chk("clr_lo_q", lo_q, '0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);
    step();
    clear = 1'b0; bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_clear_done", 32'(done), 32'd0);
      chk("post_clear_busy", 32'(busy), 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      capture($urandom, $urandom, 1'($urandom));
      if ($urandom_range(1) == 1) capture($urandom, $urandom, 1'($urandom));
      writeback(int'($urandom_range(40, 100)), 0,
                ($urandom_range(2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    repeat (3) step();
    chk("words_drained", 32'(exp_words.size()), 32'd0);
    chk("commits_drained", 32'(exp_hi.size()), 32'd0);
    chk("overrun_count", 32'(act_ovr), 32'(exp_ovr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
